// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, data width and
// the default bit period.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: both flops reset to 1 (line idle) so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling mid-bit on a CLKS_PER_BIT-cycle bit period.
// Define UART_RX_FERR_EN to add the RX_ERR pulse for framing errors and start glitches.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX,
  output logic              RX_DONE,
  output logic [DATA_W-1:0] RX_DATA
`ifdef UART_RX_FERR_EN
  ,
  output logic              RX_ERR
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be even and at least 4");
  end

  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              line;

  uart_rx_sync u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (RX),
    .q     (line)
  );

  // NOTE: one registered FSM; every state bit and output uses non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      RX_DATA   <= '0;
      RX_DONE   <= 1'b0;
    end else begin
      RX_DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Start bit is re-checked one count past its half period; a high line is a glitch.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= line;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A low stop bit drops the frame and leaves RX_DATA untouched.
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (line) begin
              state   <= DONE;
              RX_DATA <= shift_reg;
              RX_DONE <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_FERR_EN
  // Pulses on the same edge the FSM abandons the frame back to IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RX_ERR <= 1'b0;
    end else begin
      RX_ERR <= ((state == START) && (cnt == CNT_HALF) && line) ||
                ((state == STOP)  && (cnt == CNT_LAST) && !line);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16 clk/bit receiver and a 4 clk/bit receiver
// driven by a shared clock/reset, with a per-receiver expected-byte queue.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB_A = CLKS_PER_BIT_DEF;
  localparam int CPB_B = 4;
  localparam int LAT_A = 3 + CPB_A / 2 + 9 * CPB_A;
  localparam int LAT_B = 3 + CPB_B / 2 + 9 * CPB_B;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              rx_a  = 1'b1;
  logic              rx_b  = 1'b1;
  logic              done_a, done_b;
  logic [DATA_W-1:0] data_a, data_b;
`ifdef UART_RX_FERR_EN
  logic              err_a, err_b;
  int                err_cnt_a = 0;
  int                err_cnt_b = 0;
`endif

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  int   last_done_a = 0;
  int   last_done_b = 0;
  logic prev_done_a = 1'b0;
  logic prev_done_b = 1'b0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .CLK     (clk),
    .RESET   (reset),
    .RX      (rx_a),
    .RX_DONE (done_a),
    .RX_DATA (data_a)
`ifdef UART_RX_FERR_EN
    ,
    .RX_ERR  (err_a)
`endif
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .CLK     (clk),
    .RESET   (reset),
    .RX      (rx_b),
    .RX_DONE (done_b),
    .RX_DATA (data_b)
`ifdef UART_RX_FERR_EN
    ,
    .RX_ERR  (err_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; t0 is the cycle-counter value right after the edge that samples the start bit.
  task automatic send_frame(input bit use_b, input logic [7:0] b, input logic stop_bit,
                            output int t0);
    int         cpb;
    logic [9:0] frame;
    cpb   = use_b ? CPB_B : CPB_A;
    frame = {stop_bit, b, 1'b0};
    t0    = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      if (use_b) rx_b = frame[i];
      else       rx_a = frame[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  // Scoreboard side: every RX_DONE pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      last_done_a = cyc;
      check("a_pulse_width", 32'(prev_done_a), 32'd0);
      check("a_pulse_expected", 32'(exp_q_a.size() != 0), 32'd1);
      if (exp_q_a.size() != 0) check("a_rx_data", 32'(data_a), 32'(exp_q_a.pop_front()));
    end
    if (done_b) begin
      done_cnt_b++;
      last_done_b = cyc;
      check("b_pulse_width", 32'(prev_done_b), 32'd0);
      check("b_pulse_expected", 32'(exp_q_b.size() != 0), 32'd1);
      if (exp_q_b.size() != 0) check("b_rx_data", 32'(data_b), 32'(exp_q_b.pop_front()));
    end
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

`ifdef UART_RX_FERR_EN
  always @(negedge clk) begin
    if (err_a) err_cnt_a++;
    if (err_b) err_cnt_b++;
  end
`endif

  initial begin
    int t0;

    repeat (4) @(negedge clk);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
`ifdef UART_RX_FERR_EN
    check("rst_err_a", 32'(err_a), 32'd0);
`endif
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Single byte with latency measurement.
    exp_q_a.push_back(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("a5_count", 32'(done_cnt_a), 32'd1);
    check("a5_latency", 32'(last_done_a - t0), 32'(LAT_A));
    check("a5_data", 32'(data_a), 32'hA5);

    // Back-to-back frames with no idle gap.
    exp_q_a.push_back(8'h00);
    exp_q_a.push_back(8'hFF);
    send_frame(1'b0, 8'h00, 1'b1, t0);
    send_frame(1'b0, 8'hFF, 1'b1, t0);
    repeat (8) @(negedge clk);
    check("b2b_count", 32'(done_cnt_a), 32'd3);
    check("b2b_data", 32'(data_a), 32'hFF);

    // Six-cycle low glitch on an idle line.
    rx_a = 1'b0;
    repeat (6) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_count", 32'(done_cnt_a), 32'd3);
    check("glitch_data", 32'(data_a), 32'hFF);
`ifdef UART_RX_FERR_EN
    check("glitch_err", 32'(err_cnt_a), 32'd1);
`endif

    // Low stop bit: framing error, then the rest of the low stop bit re-arms
    // the receiver and is rejected as a start glitch once the line goes high.
    send_frame(1'b0, 8'h3C, 1'b0, t0);
    rx_a = 1'b1;
    repeat (3 * CPB_A) @(negedge clk);
    check("ferr_count", 32'(done_cnt_a), 32'd3);
    check("ferr_data", 32'(data_a), 32'hFF);
`ifdef UART_RX_FERR_EN
    check("ferr_err", 32'(err_cnt_a), 32'd3);
`endif

    // Reset in the middle of data bit 4 of 0x5A discards the partial frame.
    begin
      logic [9:0] frame;
      frame = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rx_a = frame[i];
        repeat (CPB_A) @(negedge clk);
      end
      rx_a = frame[5];
      repeat (CPB_A / 2) @(negedge clk);
    end
    reset = 1'b1;
    rx_a  = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_data", 32'(data_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    exp_q_a.push_back(8'h81);
    send_frame(1'b0, 8'h81, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("post_rst_count", 32'(done_cnt_a), 32'd4);
    check("post_rst_data", 32'(data_a), 32'h81);
    check("post_rst_latency", 32'(last_done_a - t0), 32'(LAT_A));

    // Minimum bit period receiver.
    exp_q_b.push_back(8'h96);
    send_frame(1'b1, 8'h96, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("cpb4_count", 32'(done_cnt_b), 32'd1);
    check("cpb4_latency", 32'(last_done_b - t0), 32'(LAT_B));
    check("cpb4_data", 32'(data_b), 32'h96);
`ifdef UART_RX_FERR_EN
    check("cpb4_err", 32'(err_cnt_b), 32'd0);
`endif

    check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: CLK cycles per serial bit; SHALL be even and >= 4.
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 RX  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 RX_DONE  output  1  one-cycle pulse: a valid byte has been received.
REQ-006 RX_DATA  output  8  last received byte; held until the next valid frame.

Function
REQ-007 RX SHALL pass through a 2-flop synchronizer before any use; "line" below means the synchronizer output.
REQ-008 The FSM SHALL have states IDLE, START, DATA, STOP, DONE, with a bit-timing counter and a 3-bit bit index.
REQ-009 IDLE: when line = 0, go to START and clear the counter; otherwise stay in IDLE.
REQ-010 START: after CLKS_PER_BIT/2 cycles (mid start bit), go to DATA if line = 0; if line = 1, treat it as a glitch and return to IDLE.
REQ-011 DATA: every CLKS_PER_BIT cycles, sample line into shift-register bit [index], LSB first.
REQ-012 DATA: after 8 samples (index wraps 7->0), go to STOP.
REQ-013 STOP: after CLKS_PER_BIT cycles (mid stop bit), sample line.
REQ-014 STOP, line = 1: go to DONE, load RX_DATA from the shift register, and assert RX_DONE for exactly that one cycle.
REQ-015 STOP, line = 0 (framing error): go to IDLE; RX_DATA is unchanged and RX_DONE stays low.
REQ-016 DONE SHALL last one cycle and then return to IDLE.
REQ-017 Re-arming requires line = 0 again in IDLE, so back-to-back frames SHALL be received without loss.
REQ-018 Latency: RX_DONE SHALL rise exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first CLK edge that samples RX = 0 (155 at the default).
REQ-019 A line change mid-bit, other than at a sample point, SHALL have no effect.
REQ-020 No more than one RX_DONE pulse per frame.

Reset
REQ-021 RESET = 1 SHALL force IDLE, RX_DONE = 0, RX_DATA = 0, counter/index/shift register = 0, synchronizer flops = 1.
REQ-022 RESET has priority over all other activity, including mid-frame; a partial frame is discarded.
REQ-023 After reset release, reception SHALL start on the next falling line.

Configuration
REQ-024 Macro UART_RX_FERR_EN, when defined, SHALL add output RX_ERR (1 bit), pulsed for one cycle on a framing error (REQ-015) or a start-bit glitch (REQ-010); reset value 0.
REQ-025 Without UART_RX_FERR_EN, RX_ERR SHALL be absent and errors are discarded silently; all other behaviour is identical.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT constant, and the data width constant (8).
REQ-027 One sub-module, uart_rx_sync (2-flop synchronizer, reset value 1), SHALL be instantiated for RX; everything else lives in uart_rx.

Verification
REQ-028 Reset, then send 0xA5 (8N1, 16 clk/bit) -> a single RX_DONE pulse at cycle 155; RX_DATA = 0xA5.
REQ-029 Frames 0x00 then 0xFF back-to-back, no idle gap -> two RX_DONE pulses; RX_DATA = 0x00, then 0xFF.
REQ-030 6-cycle low glitch on idle RX -> no RX_DONE; RX_ERR pulse when UART_RX_FERR_EN is defined; RX_DATA unchanged.
REQ-031 Send 0x3C with stop bit = 0 -> no RX_DONE; RX_DATA keeps the previous value; RX_ERR pulse when enabled.
REQ-032 Assert RESET during data bit 4 of 0x5A, then send 0x81 -> RX_DATA = 0 after reset; next RX_DONE with RX_DATA = 0x81.
REQ-033 CLKS_PER_BIT = 4, send 0x96 -> RX_DONE at cycle 41; RX_DATA = 0x96.
